// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit for the 5-stage RV32 pipeline: operand
// forwarding muxes, load-use stall, branch flush, data-memory freeze and
// saturating event counters.
module hazard_forward_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2,
    parameter int REG_SEL    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ifid_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] ifid_rs,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] idex_rs,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] idex_reg_r,
    input  logic [ADDR_WIDTH-1:0]         idex_rd,
    input  logic                          idex_ctrl_reg_w,
    input  logic                          idex_mem_read,
    input  logic [ADDR_WIDTH-1:0]         exmem_rd,
    input  logic                          exmem_ctrl_reg_w,
    input  logic [DATA_WIDTH-1:0]         exmem_ALU_data_out,
    input  logic [ADDR_WIDTH-1:0]         memwb_rd,
    input  logic                          memwb_ctrl_reg_w,
    input  logic [DATA_WIDTH-1:0]         memwb_mux_read_data,
    input  logic                          branch_taken,
    input  logic                          dmem_busy,
    output logic [NUM_SRC*DATA_WIDTH-1:0] forward_r_data,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic                          flush_if_id,
    output logic                          freeze,
    output logic [CNT_WIDTH-1:0]          cnt_load_use,
    output logic [CNT_WIDTH-1:0]          cnt_mem_wait,
    output logic [CNT_WIDTH-1:0]          cnt_flush
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       lu;
    logic [1:0] sel [NUM_SRC];

    // Select encoding: 0 = register file, 1 = EX/MEM, 2 = MEM/WB. The nearer
    // stage wins and x0 is never forwarded.
    function automatic logic [1:0] decode_sel(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic [ADDR_WIDTH-1:0] near_rd,
        input logic                  near_w,
        input logic [ADDR_WIDTH-1:0] far_rd,
        input logic                  far_w
    );
        if (near_w && (near_rd != '0) && (near_rd == rs)) return 2'd1;
        if (far_w && (far_rd != '0) && (far_rd == rs)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Load-use detect: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idex_rd == ifid_rs[i*ADDR_WIDTH +: ADDR_WIDTH]) lu = 1'b1;
        end
        lu = lu & ifid_valid & idex_mem_read & idex_ctrl_reg_w & (idex_rd != '0);
    end

    generate
        if (REG_SEL != 0) begin : g_reg_sel
            logic [1:0] sel_id_p0 [NUM_SRC];
            logic [1:0] sel_ex_p1 [NUM_SRC];

            // Decode in ID against the instructions that will sit in EX/MEM and MEM/WB next cycle.
            always_comb begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    sel_id_p0[i] = decode_sel(ifid_rs[i*ADDR_WIDTH +: ADDR_WIDTH],
                                              idex_rd, idex_ctrl_reg_w,
                                              exmem_rd, exmem_ctrl_reg_w);
                end
            end

            // ID/EX select register: cleared when EX receives a NOP, held when ID/EX holds.
            always_ff @(posedge clk) begin
                if (reset || bubble_id_ex || flush_if_id) begin
                    for (int i = 0; i < NUM_SRC; i++) sel_ex_p1[i] <= 2'd0;
                end else if (!(stall_if_id || freeze)) begin
                    for (int i = 0; i < NUM_SRC; i++) sel_ex_p1[i] <= sel_id_p0[i];
                end
            end

            // Registered selects drive the EX mux.
            always_comb begin
                for (int i = 0; i < NUM_SRC; i++) sel[i] = sel_ex_p1[i];
            end
        end else begin : g_comb_sel
            // Decode directly in EX from the current pipeline contents.
            always_comb begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    sel[i] = decode_sel(idex_rs[i*ADDR_WIDTH +: ADDR_WIDTH],
                                        exmem_rd, exmem_ctrl_reg_w,
                                        memwb_rd, memwb_ctrl_reg_w);
                end
            end
        end
    endgenerate

    // Operand mux; reset forces the register-file path.
    always_comb begin
        forward_r_data = idex_reg_r;
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                case (sel[i])
                    2'd1:    forward_r_data[i*DATA_WIDTH +: DATA_WIDTH] = exmem_ALU_data_out;
                    2'd2:    forward_r_data[i*DATA_WIDTH +: DATA_WIDTH] = memwb_mux_read_data;
                    default: ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state and control outputs; freeze outranks flush, flush outranks load-use.
    always_comb begin
        state_nxt    = state;
        freeze       = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        stall_if_id  = 1'b0;
        if (!reset) begin
            if (dmem_busy) begin
                freeze    = 1'b1;
                state_nxt = MEM_WAIT;
            end else begin
                // The exit cycle from MEM_WAIT behaves exactly like RUN.
                state_nxt = RUN;
                if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (lu) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_load_use <= '0;
            cnt_mem_wait <= '0;
            cnt_flush    <= '0;
        end else begin
            if (stall_if_id && !freeze) cnt_load_use <= sat_inc(cnt_load_use);
            if (freeze)                 cnt_mem_wait <= sat_inc(cnt_mem_wait);
            if (flush_if_id)            cnt_flush    <= sat_inc(cnt_flush);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios with literal expectations,
// then a random instruction stream through a pipeline model, comparing a
// REG_SEL=0 instance and a REG_SEL=1 / CNT_WIDTH=4 instance every cycle.
module tb_hazard_forward_unit;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic                 v;
        logic [NS-1:0][AW-1:0] rs;
        logic [AW-1:0]        rd;
        logic                 w;
        logic                 mr;
        logic                 br;
    } ins_t;

    logic clk = 1'b0;
    logic reset;
    logic ifid_valid;
    logic [NS*AW-1:0] ifid_rs, idex_rs;
    logic [NS*DW-1:0] idex_reg_r;
    logic [AW-1:0] idex_rd, exmem_rd, memwb_rd;
    logic idex_ctrl_reg_w, idex_mem_read, exmem_ctrl_reg_w, memwb_ctrl_reg_w;
    logic [DW-1:0] exmem_ALU_data_out, memwb_mux_read_data;
    logic branch_taken, dmem_busy;

    logic [NS*DW-1:0] fwd0, fwd1;
    logic stall0, bubble0, flush0, freeze0;
    logic stall1, bubble1, flush1, freeze1;
    logic [15:0] clu0, cmw0, cfl0;
    logic [3:0]  clu1, cmw1, cfl1;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;
    logic chk_regsel = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .REG_SEL(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .idex_rs(idex_rs),
        .idex_reg_r(idex_reg_r), .idex_rd(idex_rd), .idex_ctrl_reg_w(idex_ctrl_reg_w),
        .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_ctrl_reg_w(exmem_ctrl_reg_w),
        .exmem_ALU_data_out(exmem_ALU_data_out), .memwb_rd(memwb_rd), .memwb_ctrl_reg_w(memwb_ctrl_reg_w),
        .memwb_mux_read_data(memwb_mux_read_data), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .forward_r_data(fwd0), .stall_if_id(stall0), .bubble_id_ex(bubble0), .flush_if_id(flush0),
        .freeze(freeze0), .cnt_load_use(clu0), .cnt_mem_wait(cmw0), .cnt_flush(cfl0));

    hazard_forward_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .REG_SEL(1), .CNT_WIDTH(4)) dut_rs (
        .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .idex_rs(idex_rs),
        .idex_reg_r(idex_reg_r), .idex_rd(idex_rd), .idex_ctrl_reg_w(idex_ctrl_reg_w),
        .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_ctrl_reg_w(exmem_ctrl_reg_w),
        .exmem_ALU_data_out(exmem_ALU_data_out), .memwb_rd(memwb_rd), .memwb_ctrl_reg_w(memwb_ctrl_reg_w),
        .memwb_mux_read_data(memwb_mux_read_data), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .forward_r_data(fwd1), .stall_if_id(stall1), .bubble_id_ex(bubble1), .flush_if_id(flush1),
        .freeze(freeze1), .cnt_load_use(clu1), .cnt_mem_wait(cmw1), .cnt_flush(cfl1));

    // Reference model: expected controls and operands straight from the rules.
    logic e_lu, e_freeze, e_flush, e_stall, e_bubble;
    logic [NS*DW-1:0] e_fwd;
    always_comb begin
        e_lu = 1'b0;
        for (int i = 0; i < NS; i++)
            if (ifid_rs[i*AW +: AW] == idex_rd) e_lu = 1'b1;
        e_lu = e_lu && ifid_valid && idex_mem_read && idex_ctrl_reg_w && (idex_rd != 0);
        e_freeze = !reset && dmem_busy;
        e_flush  = !reset && !dmem_busy && branch_taken;
        e_stall  = !reset && !dmem_busy && !branch_taken && e_lu;
        e_bubble = e_flush || e_stall;
        e_fwd = idex_reg_r;
        for (int i = 0; i < NS; i++) begin
            if (reset) begin
            end else if (exmem_ctrl_reg_w && exmem_rd != 0 && exmem_rd == idex_rs[i*AW +: AW])
                e_fwd[i*DW +: DW] = exmem_ALU_data_out;
            else if (memwb_ctrl_reg_w && memwb_rd != 0 && memwb_rd == idex_rs[i*AW +: AW])
                e_fwd[i*DW +: DW] = memwb_mux_read_data;
        end
    end

    // Event totals (unbounded); saturation is applied at compare time.
    int m_lu = 0, m_mw = 0, m_fl = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_lu <= 0; m_mw <= 0; m_fl <= 0;
        end else begin
            if (e_stall)  m_lu <= m_lu + 1;
            if (e_freeze) m_mw <= m_mw + 1;
            if (e_flush)  m_fl <= m_fl + 1;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("fwd0", fwd0, e_fwd);
            chk("stall0", stall0, e_stall);
            chk("bubble0", bubble0, e_bubble);
            chk("flush0", flush0, e_flush);
            chk("freeze0", freeze0, e_freeze);
            chk("cnt_lu0", clu0, sat(m_lu, 65535));
            chk("cnt_mw0", cmw0, sat(m_mw, 65535));
            chk("cnt_fl0", cfl0, sat(m_fl, 65535));
            chk("stall1", stall1, e_stall);
            chk("bubble1", bubble1, e_bubble);
            chk("flush1", flush1, e_flush);
            chk("freeze1", freeze1, e_freeze);
            chk("cnt_lu1", clu1, sat(m_lu, 15));
            chk("cnt_mw1", cmw1, sat(m_mw, 15));
            chk("cnt_fl1", cfl1, sat(m_fl, 15));
            if (chk_regsel) chk("fwd_regsel", fwd1, fwd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        idex_rd = 5'd7; idex_mem_read = 1'b1; idex_ctrl_reg_w = 1'b1;
        ifid_valid = 1'b1; ifid_rs = {5'd7, 5'd3};
    endtask

    function automatic ins_t rand_ins();
        ins_t n;
        n.v  = 1'b1;
        for (int i = 0; i < NS; i++) n.rs[i] = AW'($urandom_range(0, 7));
        n.rd = AW'($urandom_range(0, 7));
        n.w  = ($urandom_range(0, 3) != 0);
        n.mr = n.w && ($urandom_range(0, 3) == 0);
        n.br = ($urandom_range(0, 11) == 0);
        return n;
    endfunction

    ins_t p_ifid, p_idex, p_exmem, p_memwb;

    task automatic drive_pipe();
        ifid_valid          = p_ifid.v;
        ifid_rs             = p_ifid.rs;
        idex_rs             = p_idex.rs;
        idex_rd             = p_idex.rd;
        idex_ctrl_reg_w     = p_idex.w;
        idex_mem_read       = p_idex.mr;
        branch_taken        = p_idex.v && p_idex.br;
        exmem_rd            = p_exmem.rd;
        exmem_ctrl_reg_w    = p_exmem.w;
        memwb_rd            = p_memwb.rd;
        memwb_ctrl_reg_w    = p_memwb.w;
        idex_reg_r          = {$urandom, $urandom};
        exmem_ALU_data_out  = $urandom;
        memwb_mux_read_data = $urandom;
    endtask

    initial begin
        reset = 1'b1; ifid_valid = 1'b0; ifid_rs = '0; idex_rs = '0;
        idex_reg_r = 64'h22222222_11111111; idex_rd = '0; idex_ctrl_reg_w = 1'b0;
        idex_mem_read = 1'b0; exmem_rd = 5'd5; exmem_ctrl_reg_w = 1'b1;
        exmem_ALU_data_out = 32'hAAAA0001; memwb_rd = 5'd5; memwb_ctrl_reg_w = 1'b1;
        memwb_mux_read_data = 32'hBBBB0002; branch_taken = 1'b1; dmem_busy = 1'b1;
        idex_rs = {5'd0, 5'd5};

        // Reset: controls low, register-file operands, counters cleared.
        tick(); tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("lit_rst_freeze", freeze0, 1'b0);
        chk("lit_rst_flush", flush0, 1'b0);
        chk("lit_rst_fwd", fwd0, 64'h22222222_11111111);
        chk("lit_rst_cnt", cfl0, 16'd0);

        // Forwarding priority and x0.
        tick(); reset = 1'b0; dmem_busy = 1'b0; branch_taken = 1'b0;
        @(negedge clk); chk("lit_fwd_exmem", fwd0, 64'h22222222_AAAA0001);
        tick(); exmem_ctrl_reg_w = 1'b0;
        @(negedge clk); chk("lit_fwd_memwb", fwd0, 64'h22222222_BBBB0002);
        tick(); exmem_ctrl_reg_w = 1'b1; idex_rs = {5'd5, 5'd0};
        @(negedge clk); chk("lit_fwd_rs0", fwd0, 64'hAAAA0001_11111111);
        tick(); exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = '0;
        @(negedge clk); chk("lit_fwd_x0", fwd0, 64'h22222222_11111111);

        // Load-use: one stall, then the dependent operand arrives from MEM/WB.
        tick(); exmem_ctrl_reg_w = 1'b0; memwb_ctrl_reg_w = 1'b0; set_lu();
        @(negedge clk);
        chk("lit_lu_stall", stall0, 1'b1);
        chk("lit_lu_bubble", bubble0, 1'b1);
        tick(); idex_rd = '0; idex_mem_read = 1'b0; idex_ctrl_reg_w = 1'b0;
        exmem_rd = 5'd7; exmem_ctrl_reg_w = 1'b1;
        @(negedge clk);
        chk("lit_lu_clear", stall0, 1'b0);
        chk("lit_lu_cnt", clu0, 16'd1);
        tick(); exmem_ctrl_reg_w = 1'b0; memwb_rd = 5'd7; memwb_ctrl_reg_w = 1'b1;
        memwb_mux_read_data = 32'hCCCC0007; idex_rs = {5'd7, 5'd3}; ifid_valid = 1'b0;
        @(negedge clk); chk("lit_lu_fwd", fwd0, 64'hCCCC0007_11111111);

        // Freeze for 4 cycles over a pending load-use.
        tick(); memwb_ctrl_reg_w = 1'b0; set_lu(); dmem_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lit_frz_freeze", freeze0, 1'b1);
            chk("lit_frz_stall", stall0, 1'b0);
            if (k < 3) tick();
        end
        tick(); dmem_busy = 1'b0;
        @(negedge clk);
        chk("lit_frz_exit_stall", stall0, 1'b1);
        chk("lit_frz_exit_freeze", freeze0, 1'b0);
        chk("lit_frz_cnt", cmw0, 16'd4);

        // Branch outranks load-use.
        tick(); branch_taken = 1'b1;
        @(negedge clk);
        chk("lit_br_flush", flush0, 1'b1);
        chk("lit_br_bubble", bubble0, 1'b1);
        chk("lit_br_stall", stall0, 1'b0);
        chk("lit_br_lucnt", clu0, 16'd2);
        tick(); branch_taken = 1'b0; idex_mem_read = 1'b0; idex_ctrl_reg_w = 1'b0;
        @(negedge clk); chk("lit_br_cnt", cfl0, 16'd1);

        // Reset in the middle of a memory wait.
        tick(); dmem_busy = 1'b1;
        @(negedge clk); chk("lit_mw_freeze", freeze0, 1'b1);
        tick(); reset = 1'b1;
        @(negedge clk); chk("lit_mw_rst_freeze", freeze0, 1'b0);
        tick(); reset = 1'b0; dmem_busy = 1'b0;
        @(negedge clk);
        chk("lit_mw_after_freeze", freeze0, 1'b0);
        chk("lit_mw_after_cnt", cmw0, 16'd0);
        chk("lit_mw_after_lucnt", clu0, 16'd0);

        // 20 load-use stall cycles: 4-bit counter pins at 15.
        tick(); set_lu();
        repeat (20) @(posedge clk);
        #1; ifid_valid = 1'b0;
        @(negedge clk);
        chk("lit_sat4", clu1, 4'd15);
        chk("lit_sat16", clu0, 16'd20);

        // Random instruction stream through a pipeline model.
        p_ifid = '0; p_idex = '0; p_exmem = '0; p_memwb = '0;
        tick(); reset = 1'b1; drive_pipe();
        tick(); reset = 1'b0; dmem_busy = 1'b0; drive_pipe();
        chk_regsel = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            if (reset) begin
                p_ifid = '0; p_idex = '0; p_exmem = '0; p_memwb = '0;
            end else if (!e_freeze) begin
                p_memwb = p_exmem;
                p_exmem = p_idex;
                p_idex  = e_bubble ? '0 : p_ifid;
                if (!e_stall) p_ifid = e_flush ? '0 : rand_ins();
            end
            #1;
            reset = ($urandom_range(0, 499) == 0);
            dmem_busy = dmem_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            drive_pipe();
        end
        @(negedge clk);
        chk_on = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
